// File: rtl/spi_reg_writer_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_writer_pkg : shared state encoding and width helpers   | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_reg_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int calc_frame_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // Counter must hold 0..FRAME_W+1 so an over-long frame stays distinguishable.
  function automatic int calc_cnt_w(input int frame_w);
    return $clog2(frame_w + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_reg_writer_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge : 2-FF synchronizer with rise/fall detect             | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

`default_nettype wire

// File: rtl/spi_reg_writer.sv
// ---------------------------------------------------------------------------
// spi_reg_writer : SPI mode-0 slave turning addr+data frames into
//                  single-cycle register bus writes               | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_reg_writer
  import spi_reg_writer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spiSck,
  input  logic              spiCsN,
  input  logic              spiMosi,
  output logic              wrEnable,
  output logic [ADDR_W-1:0] aBus,
  output logic [DATA_W-1:0] dBus,
  output logic              frameErr
);

  localparam int FRAME_W = calc_frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = calc_cnt_w(FRAME_W);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic w_sckRise;
  logic w_csRise;
  logic w_csFall;
  logic w_mosi;
  logic w_unusedSckLevel;
  logic w_unusedSckFall;
  logic w_unusedCsLevel;
  logic w_unusedMosiRise;
  logic w_unusedMosiFall;
  logic w_csFallAny;

  state_t              r_state;
  state_t              w_next;
  logic [FRAME_W-1:0]  r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_fallPend;

  sync_edge u_sync_sck (
    .clk     (clk),
    .rst     (rst),
    .i_async (spiSck),
    .o_level (w_unusedSckLevel),
    .o_rise  (w_sckRise),
    .o_fall  (w_unusedSckFall)
  );

  sync_edge u_sync_cs (
    .clk     (clk),
    .rst     (rst),
    .i_async (spiCsN),
    .o_level (w_unusedCsLevel),
    .o_rise  (w_csRise),
    .o_fall  (w_csFall)
  );

  // Same depth as sck so the sampled bit lines up with the detected edge.
  sync_edge u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .i_async (spiMosi),
    .o_level (w_mosi),
    .o_rise  (w_unusedMosiRise),
    .o_fall  (w_unusedMosiFall)
  );

  assign w_csFallAny = w_csFall | r_fallPend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_csFallAny) w_next = ST_SHIFT;
      ST_SHIFT:  if (w_csRise)    w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_fallPend <= 1'b0;
      wrEnable   <= 1'b0;
      frameErr   <= 1'b0;
      aBus       <= '0;
      dBus       <= '0;
    end else begin
      wrEnable <= 1'b0;
      frameErr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_fallPend <= 1'b0;
          if (w_csFallAny) begin
            r_shift <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_fallPend <= 1'b0;
          if (w_sckRise) begin
            r_shift <= {r_shift[FRAME_W-2:0], w_mosi};
            if (r_cnt != C_CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          // A CS fall here belongs to the next frame; hold it for IDLE.
          if (w_csFall) r_fallPend <= 1'b1;
          if (r_cnt == C_CNT_FULL) begin
            aBus     <= r_shift[FRAME_W-1 -: ADDR_W];
            dBus     <= r_shift[DATA_W-1:0];
            wrEnable <= 1'b1;
          end else if (r_cnt != '0) begin
            frameErr <= 1'b1;
          end
        end
        default: r_fallPend <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_writer.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_writer : scoreboard bench for spi_reg_writer          | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_writer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int FW = AW + DW;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          sck  = 1'b0;
  logic          csn  = 1'b1;
  logic          mosi = 1'b0;
  logic          wrEnable;
  logic          frameErr;
  logic [AW-1:0] aBus;
  logic [DW-1:0] dBus;

  typedef struct {
    bit            err;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ev_t;

  ev_t           sb[$];
  int            total = 0;
  int            bad   = 0;
  logic [AW-1:0] m_a   = '0;
  logic [DW-1:0] m_d   = '0;

  spi_reg_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .spiSck   (sck),
    .spiCsN   (csn),
    .spiMosi  (mosi),
    .wrEnable (wrEnable),
    .aBus     (aBus),
    .dBus     (dBus),
    .frameErr (frameErr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame of exactly FW bits is a write, zero bits is silent,
  // any other length is an error that leaves the bus values alone.
  task automatic model_frame(input int n, input logic [15:0] bits);
    ev_t e;
    if (n == FW) begin
      m_a = bits[FW-1 -: AW];
      m_d = bits[DW-1:0];
      e.err = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    e.a = m_a;
    e.d = m_d;
    if (n != 0) sb.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input int n, input logic [15:0] bits, input bit tight);
    for (int i = 0; i < n; i++) begin
      mosi = bits[n-1-i];
      wait_clk(5);
      sck = 1'b1;
      if (tight && i == n - 1) csn = 1'b1;
      wait_clk(5);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [15:0] bits, input int gap, input bit tight);
    model_frame(n, bits);
    csn = 1'b0;
    wait_clk(5);
    send_bits(n, bits, tight);
    if (!tight || n == 0) begin
      wait_clk(3);
      csn = 1'b1;
    end
    wait_clk(gap);
  endtask

  task automatic check_hold(input string name);
    wait_clk(12);
    chk({name, "_drained"}, sb.size(), 0);
    chk({name, "_aBus_hold"}, {28'd0, aBus}, {28'd0, m_a});
    chk({name, "_dBus_hold"}, {24'd0, dBus}, {24'd0, m_d});
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    ev_t e;
    if (wrEnable || frameErr) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: wrEnable=%0b frameErr=%0b with nothing expected",
                 wrEnable, frameErr);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, wrEnable, frameErr}, e.err ? 32'd1 : 32'd2);
        chk("aBus_at_pulse", {28'd0, aBus}, {28'd0, e.a});
        chk("dBus_at_pulse", {24'd0, dBus}, {24'd0, e.d});
      end
    end
  end

  int len_tbl[7] = '{0, 5, 11, 12, 12, 12, 13};

  initial begin
    wait_clk(3);
    chk("reset_wrEnable", {31'd0, wrEnable}, 0);
    chk("reset_frameErr", {31'd0, frameErr}, 0);
    chk("reset_aBus", {28'd0, aBus}, 0);
    chk("reset_dBus", {24'd0, dBus}, 0);
    rst = 1'b0;
    wait_clk(5);

    frame(12, 16'h03A5, 20, 1'b0);
    check_hold("valid_3_A5");

    frame(11, 16'h0555, 20, 1'b0);
    check_hold("short_11");
    frame(13, 16'h1ABC, 20, 1'b0);
    check_hold("long_13");

    frame(12, 16'h0F00, 2, 1'b0);
    frame(12, 16'h00FF, 20, 1'b0);
    check_hold("back_to_back");

    frame(0, 16'h0000, 20, 1'b0);
    check_hold("empty_frame");

    // Reset in the middle of a frame discards it and clears the bus.
    csn = 1'b0;
    wait_clk(5);
    send_bits(6, 16'h002D, 1'b0);
    rst = 1'b1;
    m_a = '0;
    m_d = '0;
    wait_clk(2);
    rst = 1'b0;
    send_bits(6, 16'h0019, 1'b0);
    wait_clk(3);
    csn = 1'b1;
    wait_clk(20);
    check_hold("reset_mid_frame");
    frame(12, 16'h073C, 20, 1'b0);
    check_hold("after_reset_7_3C");

    frame(12, 16'h0A81, 20, 1'b1);
    check_hold("tight_cs_A_81");

    for (int k = 0; k < 14; k++) begin
      frame(len_tbl[$urandom_range(0, 6)], 16'($urandom), $urandom_range(2, 8),
            1'($urandom_range(0, 1)));
    end
    check_hold("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_writer.md
Name: spi_reg_writer

Overview:
- SPI-mode-0 slave that receives address+data frames from the host MCU and drives the internal register write bus.
- The bus is wrEnable, aBus and dBus, consumed by the control registers.
- It is the initiator of the register write bus. Each valid frame produces exactly one single-cycle write.
- All SPI inputs are asynchronous to clk; they are synchronized and edge-detected internally.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 4, register address width
- FRAME_W (local), ADDR_W+DATA_W, bits per valid frame

Ports:
- clk  input  1  system clock; must be at least 8x the spiSck frequency
- rst  input  1  reset, asynchronous, active-high
- spiSck  input  1  SPI clock, async; data sampled on its rising edge
- spiCsN  input  1  SPI chip select, async, active-low
- spiMosi  input  1  SPI serial data, async, MSB first
- wrEnable  output  1  write strobe, one clk cycle per valid frame
- aBus  output  ADDR_W  register address
- dBus  output  DATA_W  register data
- frameErr  output  1  one-cycle pulse when a frame is terminated with a wrong bit count

Behaviour:
- Reset (async, rst=1):
  - wrEnable=0, frameErr=0, aBus=0, dBus=0.
  - Shift register, bit counter and synchronizers cleared.
  - State = IDLE.
- Synchronization:
  - spiSck, spiCsN and spiMosi each pass through 2 flip-flops.
  - Edge detect compares sync stage 2 with a third delayed register.
  - mosi is taken from the same-depth stage as sck, so data and clock stay aligned.
- Frame format:
  - FRAME_W bits, MSB first: address bits first, then data bits.
  - Shifted left into an internal shift register on each detected sck rising edge while the state is SHIFT.
- States:
  - IDLE: wait for a detected spiCsN falling edge. On it: clear the shift register and counter, go to SHIFT.
    - A CS already low when reset is released is ignored until it goes high and falls again.
  - SHIFT: on each sck rising edge, shift mosi in and increment the bit counter.
    - Counter saturates at FRAME_W+1.
    - On a detected CS rising edge, go to COMMIT.
    - An sck rising edge detected in the same clk cycle as the CS rising edge is still shifted and counted before the decision.
  - COMMIT (one cycle), decided on the bit count:
    - count==FRAME_W: load aBus/dBus from the shift register and pulse wrEnable.
    - count==0: do nothing (silent empty frame).
    - Any other count: pulse frameErr; aBus/dBus unchanged.
    - Always return to IDLE.
- Output timing:
  - aBus, dBus and wrEnable update on the same clk edge. wrEnable is high for exactly 1 cycle.
  - aBus/dBus hold their last committed value indefinitely; a receiver sampling on the wrEnable cycle sees stable values.
- Latency: wrEnable/frameErr assert on the 4th clk rising edge after the first edge at which spiCsN is sampled high (2 sync + 1 edge + 1 COMMIT).
- Back-to-back frames: a new CS falling edge arriving while in COMMIT is not lost. It is detected in IDLE on the following cycle, because the edge flag is held until consumed.
- sck edges seen while in IDLE or COMMIT are ignored.
- Reset mid-frame: the partial frame is discarded, no wrEnable, no frameErr.

Decomposition:
- Shared package:
  - FRAME_W computation helper.
  - State encoding constants ST_IDLE, ST_SHIFT, ST_COMMIT.
  - Counter width function clog2(FRAME_W+2).
- One sub-module: sync_edge.
  - 2-FF synchronizer plus rise/fall detect; async active-high rst.
  - Outputs: level, rise, fall.
  - Instantiated for spiSck and spiCsN. The mosi path reuses the same synchronizer with the edge outputs unused.

Test Plan:
- Frame addr=4'h3, data=8'hA5 (12 bits, sck=clk/10) -> exactly one wrEnable pulse with aBus=4'h3, dBus=8'hA5; frameErr stays 0; outputs hold afterwards.
- 11-bit frame after a valid 4'h3/8'hA5 write -> one frameErr pulse, no wrEnable, aBus=4'h3 and dBus=8'hA5 retained. 13-bit frame -> same result.
- Back-to-back frames 4'hF/8'h00 then 4'h0/8'hFF, with CS high for only 2 clk cycles between them -> two wrEnable pulses, in that order, with the matching bus values.
- CS low then high with no sck edges -> no wrEnable, no frameErr.
- rst pulsed after 6 bits while CS stays low; remaining 6 bits sent, then CS high -> no wrEnable, no frameErr, outputs are 0. A following full frame 4'h7/8'h3C writes normally.
- Final sck rising edge placed within 1 clk cycle of the CS rising edge, frame 4'hA/8'h81 -> bit counted, wrEnable pulses with aBus=4'hA and dBus=8'h81.
